load_aligner: RTL and testbench
===============================

LOAD_ALIGNER -- requirements
Module: load_aligner

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, memory beat and result width; legal values 32 and 64.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, byte address width.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous and active-high.
REQ-005 SHALL have port req_valid  input  1  load request offered.
REQ-006 SHALL have port req_ready  output  1  block can accept a request.
REQ-007 SHALL have port req_addr  input  ADDR_WIDTH  byte address of the load.
REQ-008 SHALL have port req_sx_op  input  3  isa_shared extension code: SX_0700, SX_1500, SX_3100, SXU_0700 or SXU_1500.
REQ-009 SHALL have port mem_req_valid  output  1  one-cycle memory read strobe.
REQ-010 SHALL have port mem_req_addr  output  ADDR_WIDTH  beat-aligned read address.
REQ-011 SHALL have port mem_rsp_valid  input  1  read data returned.
REQ-012 SHALL have port mem_rsp_data  input  DATA_WIDTH  read beat.
REQ-013 SHALL have port rsp_valid  output  1  result available.
REQ-014 SHALL have port rsp_ready  input  1  consumer accepts result.
REQ-015 SHALL have port rsp_data  output  DATA_WIDTH  aligned, extended result.
REQ-016 SHALL have port rsp_fault  output  1  request illegal or unsupported; rsp_data is 0.

Function
REQ-017 SHALL implement FSM states IDLE, RD0, RD1, RESP; req_ready = 1 only in IDLE.
REQ-018 SHALL accept a request when req_valid && req_ready, registering addr and op; BYTES = DATA_WIDTH/8, offset = addr mod BYTES, size = 1/2/4 by op.
REQ-019 SHALL, on accept with an op outside REQ-008, go to RESP with rsp_fault=1, rsp_data=0 and no memory access.
REQ-020 SHALL otherwise go to RD0 and assert mem_req_valid for exactly the first RD0 cycle with mem_req_addr = addr rounded down to BYTES.
REQ-021 SHALL in RD0/RD1 wait any number of cycles for mem_rsp_valid; mem_rsp_valid in IDLE or RESP is ignored.
REQ-022 SHALL on the RD0 response capture the low beat; if offset+size <= BYTES go to RESP, else split per Configuration.
REQ-023 SHALL in RD1 assert mem_req_valid for its first cycle at low address + BYTES, capture the high beat on response, then go to RESP.
REQ-024 SHALL form rsp_data as {high,low} shifted right by 8*offset, lowest size bytes kept, sign-extended from the top kept bit for SX_* ops and zero-extended for SXU_*; SX_3100 on 64-bit sign-extends bit 31.
REQ-025 SHALL assert rsp_valid the cycle after the final mem_rsp_valid, holding rsp_data and rsp_fault stable until rsp_valid && rsp_ready, then return to IDLE.
REQ-026 SHALL not accept a new request in the cycle the response handshakes (one request in flight, no bypass).

Reset
REQ-027 SHALL on rst force state IDLE, req_ready=1, mem_req_valid=0, mem_req_addr=0, rsp_valid=0, rsp_data=0, rsp_fault=0.
REQ-028 SHALL on rst mid-operation abandon the load, emit no response, and ignore late mem_rsp_valid.

Configuration
REQ-029 SHALL, with macro LOAD_ALIGNER_MISALIGNED_SPLIT_EN defined, service beat-crossing loads via RD1 (two reads).
REQ-030 SHALL, without LOAD_ALIGNER_MISALIGNED_SPLIT_EN, detect crossing at accept, issue no memory read, and go to RESP with rsp_fault=1, rsp_data=0; RD1 is unreachable.

Verification (DATA_WIDTH=32)
REQ-031 SHALL cover addr 0x1003, SX_0700, beat 0x80AABBCC at 0x1000 -> one read of 0x1000, rsp_data 0xFFFFFF80, fault 0.
REQ-032 SHALL cover addr 0x1002, SXU_1500, beat 0x80AABBCC -> rsp_data 0x000080AA.
REQ-033 SHALL cover addr 0x1003, SX_1500, beats 0x11223344 @0x1000, 0x55667788 @0x1004 -> with macro: reads 0x1000 then 0x1004, rsp_data 0xFFFF8811; without: no read, fault 1, rsp_data 0.
REQ-034 SHALL cover rsp_ready low 3 cycles -> rsp_valid, rsp_data stable, req_ready 0 throughout.
REQ-035 SHALL cover rst asserted in RD1, then mem_rsp_valid -> IDLE, rsp_valid stays 0.
REQ-036 SHALL cover req_sx_op SX_1100 -> no mem_req_valid, rsp_valid next cycle with fault 1.

Source files
------------

// File: rtl/load_aligner.sv
// Load aligner: fetches one or two memory beats for a byte/half/word load, then aligns and extends the result.
// Optional macro LOAD_ALIGNER_MISALIGNED_SPLIT_EN enables two-beat service of beat-crossing loads.
module load_aligner #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [2:0]            req_sx_op,
  output logic                  mem_req_valid,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rsp_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_fault
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int SPAN_W = OFF_W + 4;

`ifdef LOAD_ALIGNER_MISALIGNED_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  // Extension op encodings; every other code is rejected with a fault.
  localparam logic [2:0] SX_0700  = 3'd0;
  localparam logic [2:0] SX_1500  = 3'd1;
  localparam logic [2:0] SX_3100  = 3'd2;
  localparam logic [2:0] SXU_0700 = 3'd4;
  localparam logic [2:0] SXU_1500 = 3'd5;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD0  = 2'd1;
  localparam logic [1:0] RD1  = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  logic [1:0]            state_reg;
  logic [OFF_W-1:0]      offset_reg;
  logic [2:0]            op_reg;
  logic [DATA_WIDTH-1:0] low_reg;

  function automatic logic [3:0] op_size(input logic [2:0] op);
    case (op)
      SX_0700, SXU_0700: op_size = 4'd1;
      SX_1500, SXU_1500: op_size = 4'd2;
      SX_3100:           op_size = 4'd4;
      default:           op_size = 4'd0;
    endcase
  endfunction

  function automatic logic crosses(input logic [OFF_W-1:0] off, input logic [3:0] size);
    logic [SPAN_W-1:0] span;
    span = SPAN_W'(off) + SPAN_W'(size);
    crosses = span > SPAN_W'(BYTES);
  endfunction

  logic [OFF_W-1:0]        req_offset;
  logic                    req_legal;
  logic                    req_cross;
  logic                    rd_cross;
  logic [3:0]              cur_size;
  logic                    cur_signed;
  logic [2*DATA_WIDTH-1:0] combined;
  logic [2*DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0]   keep_mask;
  logic                    sign_bit;
  logic [DATA_WIDTH-1:0]   result;

  assign req_ready  = (state_reg == IDLE);
  assign req_offset = req_addr[OFF_W-1:0];
  assign req_legal  = (op_size(req_sx_op) != 4'd0);
  assign req_cross  = crosses(req_offset, op_size(req_sx_op));
  assign cur_size   = op_size(op_reg);
  assign rd_cross   = crosses(offset_reg, cur_size);
  assign cur_signed = (op_reg == SX_0700) || (op_reg == SX_1500) || (op_reg == SX_3100);

  // In RD1 the incoming beat is the high half; in RD0 it is the only (low) beat.
  always_comb begin
    combined = '0;
    if (state_reg == RD1) begin
      combined = {mem_rsp_data, low_reg};
    end else begin
      combined = {{DATA_WIDTH{1'b0}}, mem_rsp_data};
    end
    shifted   = combined >> {offset_reg, 3'b000};
    keep_mask = ~({DATA_WIDTH{1'b1}} << {cur_size, 3'b000});
    case (cur_size)
      4'd1:    sign_bit = shifted[7];
      4'd2:    sign_bit = shifted[15];
      default: sign_bit = shifted[31];
    endcase
    result = shifted[DATA_WIDTH-1:0] & keep_mask;
    if (cur_signed && sign_bit) begin
      result = result | ~keep_mask;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      offset_reg    <= '0;
      op_reg        <= '0;
      low_reg       <= '0;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
      rsp_valid     <= 1'b0;
      rsp_data      <= '0;
      rsp_fault     <= 1'b0;
    end else begin
      mem_req_valid <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            offset_reg <= req_offset;
            op_reg     <= req_sx_op;
            if (!req_legal || (req_cross && !SPLIT_EN)) begin
              state_reg <= RESP;
              rsp_valid <= 1'b1;
              rsp_fault <= 1'b1;
              rsp_data  <= '0;
            end else begin
              state_reg     <= RD0;
              mem_req_valid <= 1'b1;
              mem_req_addr  <= {req_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
            end
          end
        end
        RD0: begin
          if (mem_rsp_valid) begin
            low_reg <= mem_rsp_data;
            if (SPLIT_EN && rd_cross) begin
              state_reg     <= RD1;
              mem_req_valid <= 1'b1;
              mem_req_addr  <= mem_req_addr + ADDR_WIDTH'(BYTES);
            end else begin
              state_reg <= RESP;
              rsp_valid <= 1'b1;
              rsp_fault <= 1'b0;
              rsp_data  <= result;
            end
          end
        end
        RD1: begin
          if (mem_rsp_valid) begin
            state_reg <= RESP;
            rsp_valid <= 1'b1;
            rsp_fault <= 1'b0;
            rsp_data  <= result;
          end
        end
        default: begin
          if (rsp_ready) begin
            state_reg <= IDLE;
            rsp_valid <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_aligner.sv
// Directed testbench for load_aligner (DATA_WIDTH=32); inputs driven and outputs sampled on the falling edge.
module tb_load_aligner;

  localparam logic [2:0] SX_0700  = 3'd0;
  localparam logic [2:0] SX_1500  = 3'd1;
  localparam logic [2:0] SX_3100  = 3'd2;
  localparam logic [2:0] SX_1100  = 3'd3;
  localparam logic [2:0] SXU_0700 = 3'd4;
  localparam logic [2:0] SXU_1500 = 3'd5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [2:0]  req_sx_op = '0;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_fault;

  int checks = 0;
  int errors = 0;
  int reads  = 0;

  load_aligner #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_sx_op(req_sx_op),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_fault(rsp_fault)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_req_valid) reads <= reads + 1;
  end

  task automatic issue(input logic [31:0] a, input logic [2:0] op);
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = a;
    req_sx_op = op;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic respond(input logic [31:0] d);
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = d;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
  endtask

  task automatic handshake;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || mem_req_valid !== 1'b0 || mem_req_addr !== 32'h0 ||
        rsp_valid !== 1'b0 || rsp_data !== 32'h0 || rsp_fault !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got rdy=%b mv=%b ma=%h rv=%b rd=%h rf=%b required 1 0 0 0 0 0",
               req_ready, mem_req_valid, mem_req_addr, rsp_valid, rsp_data, rsp_fault);
    end
    rst = 1'b0;
    @(negedge clk);
    $display("reset released");
  endtask

  // Single-beat loads: one read at the aligned address, result checked the cycle after the response.
  task automatic test_aligned;
    logic [31:0] addrs [6] = '{32'h1003, 32'h1002, 32'h1000, 32'h1001, 32'h1000, 32'h1002};
    logic [2:0]  ops   [6] = '{SX_0700, SXU_1500, SX_3100, SX_0700, SXU_0700, SX_1500};
    logic [31:0] exps  [6] = '{32'hFFFFFF80, 32'h000080AA, 32'h80AABBCC, 32'hFFFFFFBB,
                               32'h000000CC, 32'hFFFF80AA};
    int base;
    for (int i = 0; i < 6; i++) begin
      base = reads;
      issue(addrs[i], ops[i]);
      checks++;
      if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h1000 || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL aligned_mem_req[%0d] got v=%b a=%h rdy=%b required 1 00001000 0",
                 i, mem_req_valid, mem_req_addr, req_ready);
      end
      @(negedge clk);
      checks++;
      if (mem_req_valid !== 1'b0) begin
        errors++;
        $display("FAIL aligned_strobe_len[%0d] got %b required 0", i, mem_req_valid);
      end
      respond(32'h80AABBCC);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== exps[i] || rsp_fault !== 1'b0 || reads - base !== 1) begin
        errors++;
        $display("FAIL aligned_rsp[%0d] got v=%b d=%h f=%b reads=%0d required 1 %h 0 1",
                 i, rsp_valid, rsp_data, rsp_fault, reads - base, exps[i]);
      end
      $display("load addr=%h op=%0d data=%h fault=%b", addrs[i], ops[i], rsp_data, rsp_fault);
      handshake();
    end
  endtask

  task automatic test_split;
    int base;
    base = reads;
    issue(32'h1003, SX_1500);
`ifdef LOAD_ALIGNER_MISALIGNED_SPLIT_EN
    checks++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h1000) begin
      errors++;
      $display("FAIL split_first_read got v=%b a=%h required 1 00001000", mem_req_valid, mem_req_addr);
    end
    @(negedge clk);
    respond(32'h11223344);
    checks++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h1004 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL split_second_read got v=%b a=%h rv=%b required 1 00001004 0",
               mem_req_valid, mem_req_addr, rsp_valid);
    end
    @(negedge clk);
    respond(32'h55667788);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'hFFFF8811 || rsp_fault !== 1'b0 || reads - base !== 2) begin
      errors++;
      $display("FAIL split_rsp got v=%b d=%h f=%b reads=%0d required 1 ffff8811 0 2",
               rsp_valid, rsp_data, rsp_fault, reads - base);
    end
`else
    checks++;
    if (mem_req_valid !== 1'b0 || rsp_valid !== 1'b1 || rsp_fault !== 1'b1 ||
        rsp_data !== 32'h0 || reads - base !== 0) begin
      errors++;
      $display("FAIL split_fault got mv=%b rv=%b f=%b d=%h reads=%0d required 0 1 1 0 0",
               mem_req_valid, rsp_valid, rsp_fault, rsp_data, reads - base);
    end
`endif
    $display("split addr=00001003 data=%h fault=%b", rsp_data, rsp_fault);
    handshake();
  endtask

  // Hold the response for three cycles, then try to sneak a request into the handshake cycle.
  task automatic test_back_pressure;
    issue(32'h1001, SXU_1500);
    respond(32'hDEADBEEF);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 32'h0000ADBE || rsp_fault !== 1'b0 || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold[%0d] got v=%b d=%h f=%b rdy=%b required 1 0000adbe 0 0",
                 i, rsp_valid, rsp_data, rsp_fault, req_ready);
      end
    end
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_addr  = 32'h2000;
    req_sx_op = SX_3100;
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || mem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL no_bypass got rv=%b rdy=%b mv=%b required 0 1 0", rsp_valid, req_ready, mem_req_valid);
    end
    $display("back pressure released data=0000adbe");
  endtask

  task automatic test_reset_mid;
    issue(32'h1003, SX_1500);
    @(negedge clk);
`ifdef LOAD_ALIGNER_MISALIGNED_SPLIT_EN
    respond(32'h11223344);
`endif
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    respond(32'h55667788);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || mem_req_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid[%0d] got rv=%b rdy=%b mv=%b required 0 1 0",
                 i, rsp_valid, req_ready, mem_req_valid);
      end
      @(negedge clk);
    end
    respond(32'hCAFEF00D);
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_rsp_ignored got %b required 0", rsp_valid);
    end
    $display("mid-load reset abandoned");
  endtask

  task automatic test_illegal_op;
    logic [2:0] bad [3] = '{SX_1100, 3'd6, 3'd7};
    int base;
    for (int i = 0; i < 3; i++) begin
      base = reads;
      issue(32'h1000, bad[i]);
      checks++;
      if (mem_req_valid !== 1'b0 || rsp_valid !== 1'b1 || rsp_fault !== 1'b1 ||
          rsp_data !== 32'h0 || reads - base !== 0) begin
        errors++;
        $display("FAIL illegal_op[%0d] got mv=%b rv=%b f=%b d=%h reads=%0d required 0 1 1 0 0",
                 i, mem_req_valid, rsp_valid, rsp_fault, rsp_data, reads - base);
      end
      $display("illegal op=%0d fault=%b", bad[i], rsp_fault);
      handshake();
    end
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_split();
    test_back_pressure();
    test_reset_mid();
    test_illegal_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
